lift_door_ctrl: RTL and testbench

// Door sequencer for one lift car. On arrival at a floor it latches the floor number and runs the door

---
 rtl/lift_door_ctrl.sv | 129 ++++++++++++
 tb/tb_lift_door_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lift_door_ctrl.sv
// Door sequencer for one lift car: latches the arrival floor and runs the
// door through OPENING, OPEN (dwell) and CLOSING using a prescaled tick.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   arrive/arrive_floor arrival pulse and floor index
//   car_stopped         qualifies btn_open while CLOSED
//   btn_open/btn_close  debounced door buttons (level)
//   obstruct            door-edge sensor (level)
//   lift_open/lift_num  door-not-closed flag and owning floor
//   door_busy           same as lift_open, blocks car motion
//   door_closed         1-cycle pulse when the door finishes closing
module lift_door_ctrl #(
   parameter int FLOORS     = 16,
   parameter int TICK_DIV   = 4,
   parameter int MOVE_TICKS = 2,
   parameter int OPEN_TICKS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       arrive,
   input  logic [3:0] arrive_floor,
   input  logic       car_stopped,
   input  logic       btn_open,
   input  logic       btn_close,
   input  logic       obstruct,
   output logic       lift_open,
   output logic [3:0] lift_num,
   output logic       door_busy,
   output logic       door_closed
);

   localparam int PMAX = (MOVE_TICKS > OPEN_TICKS) ? MOVE_TICKS : OPEN_TICKS;
   localparam int PW   = $clog2(PMAX + 1);
   localparam int DW   = $clog2(TICK_DIV + 1);

   typedef enum logic [1:0] {
      S_CLOSED,
      S_OPENING,
      S_OPEN,
      S_CLOSING
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] presc_q, presc_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [3:0]    num_q, num_d;
   logic          open_q;
   logic          closed_q, closed_d;
   logic          tick;
   logic          move_done;
   logic          open_done;
   logic          floor_ok;
   logic          hold;

   assign tick      = (presc_q == DW'(TICK_DIV - 1));
   assign move_done = tick && (phase_q == PW'(MOVE_TICKS - 1));
   assign open_done = tick && (phase_q == PW'(OPEN_TICKS - 1));
   assign floor_ok  = (32'(arrive_floor) < FLOORS);
   assign hold      = obstruct | btn_open;

   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      closed_d = 1'b0;
      presc_d  = tick ? '0 : presc_q + DW'(1);
      phase_d  = tick ? phase_q + PW'(1) : phase_q;
      unique case (state_q)
         S_CLOSED: begin
            presc_d = '0;
            phase_d = '0;
            if (arrive && floor_ok) begin
               num_d   = arrive_floor;
               state_d = S_OPENING;
            end else if (btn_open && car_stopped) begin
               state_d = S_OPENING;
            end
         end
         S_OPENING: begin
            if (move_done) state_d = S_OPEN;
         end
         S_OPEN: begin
            if (hold) begin
               // dwell restarts from zero once released
               presc_d = '0;
               phase_d = '0;
            end else if (btn_close || open_done) begin
               state_d = S_CLOSING;
            end
         end
         S_CLOSING: begin
            if (hold) begin
               state_d = S_OPENING;
            end else if (move_done) begin
               state_d  = S_CLOSED;
               closed_d = 1'b1;
            end
         end
      endcase
      // every phase entry starts a fresh timing window
      if (state_d != state_q) begin
         presc_d = '0;
         phase_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_CLOSED;
         presc_q  <= '0;
         phase_q  <= '0;
         num_q    <= '0;
         open_q   <= 1'b0;
         closed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         phase_q  <= phase_d;
         num_q    <= num_d;
         open_q   <= (state_d != S_CLOSED);
         closed_q <= closed_d;
      end
   end

   assign lift_open   = open_q;
   assign door_busy   = open_q;
   assign lift_num    = num_q;
   assign door_closed = closed_q;

endmodule

// File: tb/tb_lift_door_ctrl.sv
// Directed bench for lift_door_ctrl (TICK_DIV=4, MOVE_TICKS=2, OPEN_TICKS=3).
// A second instance with FLOORS=10 covers the invalid-floor drop.
module tb_lift_door_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       arrive;
   logic [3:0] arrive_floor;
   logic       car_stopped;
   logic       btn_open;
   logic       btn_close;
   logic       obstruct;
   logic       lift_open, door_busy, door_closed;
   logic [3:0] lift_num;
   logic       lo10, db10, dc10;
   logic [3:0] ln10;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int hi_cnt = 0;
   int dc_cnt = 0;
   int dc_cyc = -1;
   int num_err = 0;
   int busy_err = 0;
   logic [3:0] want_num = 4'd0;

   lift_door_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .arrive(arrive),
      .arrive_floor(arrive_floor), .car_stopped(car_stopped),
      .btn_open(btn_open), .btn_close(btn_close), .obstruct(obstruct),
      .lift_open(lift_open), .lift_num(lift_num),
      .door_busy(door_busy), .door_closed(door_closed)
   );

   lift_door_ctrl #(.FLOORS(10)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .arrive(arrive),
      .arrive_floor(arrive_floor), .car_stopped(car_stopped),
      .btn_open(btn_open), .btn_close(btn_close), .obstruct(obstruct),
      .lift_open(lo10), .lift_num(ln10),
      .door_busy(db10), .door_closed(dc10)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (lift_open) hi_cnt++;
      if (door_closed) begin
         dc_cnt++;
         dc_cyc = cyc;
      end
      if (lift_open && lift_num !== want_num) num_err++;
      if (door_busy !== lift_open) busy_err++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic clr_mon();
      hi_cnt   = 0;
      dc_cnt   = 0;
      dc_cyc   = -1;
      num_err  = 0;
      busy_err = 0;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      arrive       = 1'b0;
      arrive_floor = 4'd0;
      btn_open     = 1'b0;
      btn_close    = 1'b0;
      obstruct     = 1'b0;
      steps(2);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic arrive_at(input logic [3:0] f);
      arrive_floor = f;
      arrive       = 1'b1;
      clr_mon();
      cyc = 0;
      step();
      arrive = 1'b0;
   endtask

   initial begin
      car_stopped = 1'b1;
      do_reset();
      chk("rst open", lift_open, 0);
      chk("rst num", lift_num, 0);
      chk("rst busy", door_busy, 0);
      chk("rst closed", door_closed, 0);

      // normal cycle at floor 5
      want_num = 4'd5;
      arrive_at(4'd5);
      chk("t1 open", lift_open, 1);
      chk("t1 num", lift_num, 5);
      steps(34);
      chk("t1 hi", hi_cnt, 28);
      chk("t1 dc cnt", dc_cnt, 1);
      chk("t1 dc cyc", dc_cyc, 29);
      chk("t1 num err", num_err, 0);
      chk("t1 busy err", busy_err, 0);
      chk("t1 num kept", lift_num, 5);

      // early close on 3rd OPEN cycle
      arrive_at(4'd5);
      steps(10);
      btn_close = 1'b1;
      step();
      btn_close = 1'b0;
      steps(15);
      chk("t2 hi", hi_cnt, 19);
      chk("t2 dc cnt", dc_cnt, 1);
      chk("t2 dc cyc", dc_cyc, 20);

      // obstruction during CLOSING reopens fully
      arrive_at(4'd5);
      steps(24);
      obstruct = 1'b1;
      step();
      obstruct = 1'b0;
      chk("t3 reopen", lift_open, 1);
      steps(34);
      chk("t3 hi", hi_cnt, 53);
      chk("t3 dc cnt", dc_cnt, 1);
      chk("t3 dc cyc", dc_cyc, 54);

      // arrive ignored while open, btn_open extends dwell
      arrive_at(4'd5);
      steps(9);
      arrive_floor = 4'd7;
      arrive       = 1'b1;
      step();
      arrive = 1'b0;
      chk("t5 num", lift_num, 5);
      step();
      btn_open = 1'b1;
      steps(20);
      btn_open = 1'b0;
      steps(25);
      chk("t5 hi", hi_cnt, 51);
      chk("t5 dc cnt", dc_cnt, 1);
      chk("t5 dc cyc", dc_cyc, 52);
      chk("t5 num err", num_err, 0);
      chk("t5 busy err", busy_err, 0);

      // async reset mid-OPEN
      want_num = 4'd9;
      arrive_at(4'd9);
      steps(11);
      clr_mon();
      #2 rst_n = 1'b0;
      #1;
      chk("t6 rst open", lift_open, 0);
      chk("t6 rst busy", door_busy, 0);
      chk("t6 rst num", lift_num, 0);
      steps(2);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("t6 idle", lift_open, 0);
      want_num    = 4'd0;
      car_stopped = 1'b0;
      btn_open    = 1'b1;
      steps(5);
      chk("t6 no open", hi_cnt, 0);
      chk("t6 no dc", dc_cnt, 0);
      car_stopped = 1'b1;
      step();
      btn_open = 1'b0;
      chk("t6 btn open", lift_open, 1);
      chk("t6 btn num", lift_num, 0);

      // invalid floors on the FLOORS=10 instance
      do_reset();
      arrive_floor = 4'd12;
      arrive       = 1'b1;
      step();
      arrive = 1'b0;
      chk("t4 f12 open", lo10, 0);
      chk("t4 f12 num", ln10, 0);
      chk("t4 f12 d16", lift_open, 1);
      chk("t4 f12 n16", lift_num, 12);
      steps(3);
      chk("t4 f12 late", lo10, 0);
      do_reset();
      arrive_floor = 4'd10;
      arrive       = 1'b1;
      step();
      chk("t4 f10 open", lo10, 0);
      arrive_floor = 4'd9;
      step();
      arrive = 1'b0;
      chk("t4 f9 open", lo10, 1);
      chk("t4 f9 num", ln10, 9);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
